// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a word-wide data memory.
// Sub-word stores become read-merge-write so the memory only sees full words.
module dmem_arbiter #(
    parameter int MEM_WORDS = 32,
    parameter bit RR_EN     = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,

    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic        req0_we_i,
    input  logic [31:0] req0_addr_i,
    input  logic [31:0] req0_wdata_i,
    input  logic [1:0]  req0_size_i,
    output logic        resp0_valid_o,
    output logic [31:0] resp0_rdata_o,
    output logic        resp0_err_o,

    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic        req1_we_i,
    input  logic [31:0] req1_addr_i,
    input  logic [31:0] req1_wdata_i,
    input  logic [1:0]  req1_size_i,
    output logic        resp1_valid_o,
    output logic [31:0] resp1_rdata_o,
    output logic        resp1_err_o,

    output logic [31:0] daddr_o,
    output logic [31:0] dwdata_o,
    input  logic [31:0] drdata_i,
    output logic [1:0]  dsize_o,
    output logic        drd_o,
    output logic        dwr_o,
    output logic [3:0]  dbe_o
);

    localparam logic [1:0]  SIZE_BYTE = 2'b00;
    localparam logic [1:0]  SIZE_HALF = 2'b01;
    localparam logic [1:0]  SIZE_WORD = 2'b10;
    localparam logic [1:0]  SIZE_BAD  = 2'b11;
    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, RESP} state_t;

    state_t      state_reg, state_next;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [1:0]  size_reg;
    logic        owner_reg;
    logic        err_reg;
    logic        rr_last_reg;
    logic [31:0] rdata_reg;
    logic [31:0] merged_reg;

    logic        grant_any;
    logic        grant_id;
    logic        accept;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [1:0]  sel_size;
    logic        sel_err;

    // rr_last_reg holds the last owner; on a tie the other port wins.
    always_comb begin
        grant_any = req0_valid_i | req1_valid_i;
        if (req0_valid_i && req1_valid_i) begin
            grant_id = RR_EN ? ~rr_last_reg : 1'b0;
        end else begin
            grant_id = ~req0_valid_i;
        end
    end

    assign accept    = (state_reg == IDLE) && grant_any && !reset_i;
    assign sel_we    = grant_id ? req1_we_i    : req0_we_i;
    assign sel_addr  = grant_id ? req1_addr_i  : req0_addr_i;
    assign sel_wdata = grant_id ? req1_wdata_i : req0_wdata_i;
    assign sel_size  = grant_id ? req1_size_i  : req0_size_i;

    assign sel_err = (sel_size == SIZE_BAD)
                   || ((sel_size == SIZE_HALF) && sel_addr[0])
                   || ((sel_size == SIZE_WORD) && (sel_addr[1:0] != 2'b00))
                   || (sel_addr[31:2] >= WORD_LIMIT);

    logic [31:0] rd_shifted;
    logic [31:0] rd_data;
    logic [3:0]  lane_mask;
    logic [31:0] wr_shifted;
    logic [31:0] merge_word;

    assign rd_shifted = drdata_i >> {addr_reg[1:0], 3'b000};
    always_comb begin
        case (size_reg)
            SIZE_BYTE: rd_data = {24'h0, rd_shifted[7:0]};
            SIZE_HALF: rd_data = {16'h0, rd_shifted[15:0]};
            default:   rd_data = rd_shifted;
        endcase
    end

    assign lane_mask  = ((size_reg == SIZE_BYTE) ? 4'b0001 : 4'b0011) << addr_reg[1:0];
    assign wr_shifted = wdata_reg << {addr_reg[1:0], 3'b000};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merge_word[8*gi +: 8] = lane_mask[gi] ? wr_shifted[8*gi +: 8]
                                                         : drdata_i[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (sel_err)                     state_next = RESP;
                    else if (!sel_we)                state_next = READ;
                    else if (sel_size == SIZE_WORD)  state_next = WRITE;
                    else                             state_next = MERGE;
                end
            end
            READ:    state_next = RESP;
            MERGE:   state_next = WRITE;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Everything is forced low while reset_i is high, including the ready path.
    always_comb begin
        req0_ready_o  = 1'b0;
        req1_ready_o  = 1'b0;
        resp0_valid_o = 1'b0;
        resp1_valid_o = 1'b0;
        resp0_rdata_o = 32'h0;
        resp1_rdata_o = 32'h0;
        resp0_err_o   = 1'b0;
        resp1_err_o   = 1'b0;
        daddr_o       = 32'h0;
        dwdata_o      = 32'h0;
        dsize_o       = 2'b00;
        drd_o         = 1'b0;
        dwr_o         = 1'b0;
        dbe_o         = 4'b0000;
        if (!reset_i) begin
            case (state_reg)
                IDLE: begin
                    req0_ready_o = grant_any && !grant_id;
                    req1_ready_o = grant_any && grant_id;
                end
                READ, MERGE: begin
                    drd_o   = 1'b1;
                    daddr_o = {2'b00, addr_reg[31:2]};
                    dsize_o = SIZE_WORD;
                    dbe_o   = 4'b1111;
                end
                WRITE: begin
                    dwr_o    = 1'b1;
                    daddr_o  = {2'b00, addr_reg[31:2]};
                    dsize_o  = SIZE_WORD;
                    dbe_o    = 4'b1111;
                    dwdata_o = (size_reg == SIZE_WORD) ? wdata_reg : merged_reg;
                end
                RESP: begin
                    if (owner_reg) begin
                        resp1_valid_o = 1'b1;
                        resp1_err_o   = err_reg;
                        resp1_rdata_o = (!we_reg && !err_reg) ? rdata_reg : 32'h0;
                    end else begin
                        resp0_valid_o = 1'b1;
                        resp0_err_o   = err_reg;
                        resp0_rdata_o = (!we_reg && !err_reg) ? rdata_reg : 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg   <= IDLE;
            rr_last_reg <= 1'b1;
            we_reg      <= 1'b0;
            addr_reg    <= 32'h0;
            wdata_reg   <= 32'h0;
            size_reg    <= 2'b00;
            owner_reg   <= 1'b0;
            err_reg     <= 1'b0;
            rdata_reg   <= 32'h0;
            merged_reg  <= 32'h0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                we_reg      <= sel_we;
                addr_reg    <= sel_addr;
                wdata_reg   <= sel_wdata;
                size_reg    <= sel_size;
                owner_reg   <= grant_id;
                rr_last_reg <= grant_id;
                err_reg     <= sel_err;
                rdata_reg   <= 32'h0;
            end
            if (state_reg == READ) begin
                rdata_reg <= rd_data;
            end
            if (state_reg == MERGE) begin
                merged_reg <= merge_word;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: round-robin instance with a memory model,
// plus a fixed-priority instance used for the arbitration comparison.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i;
    logic        r0_valid, r0_ready, r0_we, s0_valid, s0_err;
    logic [31:0] r0_addr, r0_wdata, s0_rdata;
    logic [1:0]  r0_size;
    logic        r1_valid, r1_ready, r1_we, s1_valid, s1_err;
    logic [31:0] r1_addr, r1_wdata, s1_rdata;
    logic [1:0]  r1_size;
    logic [31:0] daddr, dwdata, drdata;
    logic [1:0]  dsize;
    logic        drd, dwr;
    logic [3:0]  dbe;

    logic [31:0] mem [0:31] = '{default: 32'h0};
    assign drdata = drd ? mem[daddr[4:0]] : 32'h0;
    always @(posedge clk) if (dwr) mem[daddr[4:0]] <= dwdata;

    dmem_arbiter #(.MEM_WORDS(32), .RR_EN(1'b1)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .req0_valid_i(r0_valid), .req0_ready_o(r0_ready), .req0_we_i(r0_we),
        .req0_addr_i(r0_addr), .req0_wdata_i(r0_wdata), .req0_size_i(r0_size),
        .resp0_valid_o(s0_valid), .resp0_rdata_o(s0_rdata), .resp0_err_o(s0_err),
        .req1_valid_i(r1_valid), .req1_ready_o(r1_ready), .req1_we_i(r1_we),
        .req1_addr_i(r1_addr), .req1_wdata_i(r1_wdata), .req1_size_i(r1_size),
        .resp1_valid_o(s1_valid), .resp1_rdata_o(s1_rdata), .resp1_err_o(s1_err),
        .daddr_o(daddr), .dwdata_o(dwdata), .drdata_i(drdata), .dsize_o(dsize),
        .drd_o(drd), .dwr_o(dwr), .dbe_o(dbe)
    );

    // Fixed-priority instance: loads only, fed from the same memory contents.
    logic        b_valid, b_r0, b_r1, b_s0v, b_s0e, b_s1v, b_s1e, b_drd, b_dwr;
    logic [31:0] b_s0d, b_s1d, b_daddr, b_dwdata, b_drdata;
    logic [1:0]  b_dsize;
    logic [3:0]  b_dbe;
    assign b_drdata = b_drd ? mem[b_daddr[4:0]] : 32'h0;

    dmem_arbiter #(.MEM_WORDS(32), .RR_EN(1'b0)) dut_fp (
        .clk_i(clk), .reset_i(reset_i),
        .req0_valid_i(b_valid), .req0_ready_o(b_r0), .req0_we_i(1'b0),
        .req0_addr_i(32'h10), .req0_wdata_i(32'h0), .req0_size_i(2'b10),
        .resp0_valid_o(b_s0v), .resp0_rdata_o(b_s0d), .resp0_err_o(b_s0e),
        .req1_valid_i(b_valid), .req1_ready_o(b_r1), .req1_we_i(1'b0),
        .req1_addr_i(32'h20), .req1_wdata_i(32'h0), .req1_size_i(2'b10),
        .resp1_valid_o(b_s1v), .resp1_rdata_o(b_s1d), .resp1_err_o(b_s1e),
        .daddr_o(b_daddr), .dwdata_o(b_dwdata), .drdata_i(b_drdata), .dsize_o(b_dsize),
        .drd_o(b_drd), .dwr_o(b_dwr), .dbe_o(b_dbe)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Per-transaction observations from the memory side.
    int          rd_cnt, wr_cnt;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_be;

    task automatic run_req(input logic port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size,
                           output logic [31:0] rdata, output logic err, output int lat);
        logic seen;
        @(negedge clk);
        if (port) begin
            r1_valid = 1'b1; r1_we = we; r1_addr = addr; r1_wdata = wdata; r1_size = size;
        end else begin
            r0_valid = 1'b1; r0_we = we; r0_addr = addr; r0_wdata = wdata; r0_size = size;
        end
        #1;
        chk("ready", {31'h0, port ? r1_ready : r0_ready}, 32'h1);
        rd_cnt = 0; wr_cnt = 0; wr_addr = 0; wr_data = 0; wr_be = 0;
        rdata = 32'hX; err = 1'bX; lat = 99; seen = 1'b0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(negedge clk);
            r0_valid = 1'b0; r1_valid = 1'b0;
            #1;
            if (drd) rd_cnt++;
            if (dwr) begin
                wr_cnt++; wr_addr = daddr; wr_data = dwdata; wr_be = dbe;
            end
            if (port ? s1_valid : s0_valid) begin
                seen = 1'b1; lat = k;
                rdata = port ? s1_rdata : s0_rdata;
                err   = port ? s1_err : s0_err;
            end
        end
        @(negedge clk); #1;
        chk("resp_one_cycle", {30'h0, s1_valid, s0_valid}, 32'h0);
        $display("txn port=%0d we=%0d addr=%h size=%0d lat=%0d rdata=%h err=%0d",
                 port, we, addr, size, lat, rdata, err);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lt;
    logic [1:0]  grant_a [8];
    logic [1:0]  grant_b [8];
    int          na, nb, bad;

    initial begin
        reset_i = 1'b1;
        r0_valid = 1'b1; r0_we = 0; r0_addr = 32'h10; r0_wdata = 0; r0_size = 2'b10;
        r1_valid = 1'b0; r1_we = 0; r1_addr = 0; r1_wdata = 0; r1_size = 2'b10;
        b_valid = 1'b0;
        @(negedge clk); #1;
        chk("reset_ready0", {31'h0, r0_ready}, 32'h0);
        chk("reset_strobes", {29'h0, drd, dwr, s0_valid}, 32'h0);
        @(negedge clk);
        r0_valid = 1'b0; reset_i = 1'b0;
        #1;
        chk("idle_no_ready", {30'h0, r1_ready, r0_ready}, 32'h0);

        // Word store then word load.
        run_req(0, 1, 32'h10, 32'hDEADBEEF, 2'b10, rd, er, lt);
        chk("wst_lat", lt, 2);
        chk("wst_err", {31'h0, er}, 0);
        chk("wst_daddr", wr_addr, 32'h4);
        chk("wst_dbe", {28'h0, wr_be}, 32'hF);
        chk("wst_data", wr_data, 32'hDEADBEEF);
        chk("wst_rd", rd_cnt, 0);
        run_req(0, 0, 32'h10, 32'h0, 2'b10, rd, er, lt);
        chk("wld_lat", lt, 2);
        chk("wld_rdata", rd, 32'hDEADBEEF);
        chk("wld_err", {31'h0, er}, 0);

        // Byte store with junk in the upper wdata bits, then sub-word loads.
        run_req(0, 1, 32'h11, 32'h123456AB, 2'b00, rd, er, lt);
        chk("bst_lat", lt, 3);
        chk("bst_data", wr_data, 32'hDEADABEF);
        chk("bst_rdwr", {rd_cnt[15:0], wr_cnt[15:0]}, 32'h0001_0001);
        chk("bst_rdata", rd, 32'h0);
        run_req(1, 0, 32'h13, 32'h0, 2'b00, rd, er, lt);
        chk("bld_rdata", rd, 32'h000000DE);
        chk("bld_lat", lt, 2);
        run_req(0, 0, 32'h12, 32'h0, 2'b01, rd, er, lt);
        chk("hld_rdata", rd, 32'h0000DEAD);
        run_req(1, 1, 32'h14, 32'hCAFE, 2'b01, rd, er, lt);
        chk("hst_data", wr_data, 32'h0000CAFE);
        chk("hst_daddr", wr_addr, 32'h5);

        // Error cases: resp at T+1, no memory strobe.
        run_req(0, 0, 32'h05, 0, 2'b01, rd, er, lt);
        chk("err_half", {rd[15:0], 7'h0, er, lt[7:0]}, 32'h0000_0101);
        chk("err_half_strb", rd_cnt + wr_cnt, 0);
        run_req(1, 0, 32'h06, 0, 2'b10, rd, er, lt);
        chk("err_word", {rd[15:0], 7'h0, er, lt[7:0]}, 32'h0000_0101);
        chk("err_word_strb", rd_cnt + wr_cnt, 0);
        run_req(0, 1, 32'h00, 32'h1, 2'b11, rd, er, lt);
        chk("err_size", {rd[15:0], 7'h0, er, lt[7:0]}, 32'h0000_0101);
        chk("err_size_strb", rd_cnt + wr_cnt, 0);
        run_req(0, 0, 32'h80, 0, 2'b10, rd, er, lt);
        chk("err_range", {rd[15:0], 7'h0, er, lt[7:0]}, 32'h0000_0101);
        chk("err_range_strb", rd_cnt + wr_cnt, 0);
        run_req(0, 0, 32'h7C, 0, 2'b10, rd, er, lt);
        chk("top_word_ok", {31'h0, er}, 0);

        // Reset during MERGE aborts the store.
        run_req(0, 1, 32'h20, 32'h55667788, 2'b10, rd, er, lt);
        @(negedge clk);
        r1_valid = 1'b1; r1_we = 1; r1_addr = 32'h22; r1_wdata = 32'h0000BEEF; r1_size = 2'b01;
        #1;
        chk("abort_ready", {31'h0, r1_ready}, 32'h1);
        @(negedge clk);
        r1_valid = 1'b0;
        #1;
        chk("abort_in_merge", {31'h0, drd}, 32'h1);
        reset_i = 1'b1;
        #1;
        chk("abort_reset_outs", {30'h0, drd, dwr}, 32'h0);
        @(negedge clk);
        reset_i = 1'b0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (dwr || s1_valid) bad++;
            @(negedge clk);
        end
        chk("abort_no_write_resp", bad, 0);
        run_req(0, 0, 32'h20, 0, 2'b10, rd, er, lt);
        chk("abort_word8", rd, 32'h55667788);
        chk("abort_next_lat", lt, 2);

        // Arbitration with both ports permanently valid.
        @(negedge clk); reset_i = 1'b1;
        @(negedge clk); reset_i = 1'b0;
        r0_valid = 1; r0_we = 0; r0_addr = 32'h10; r0_size = 2'b10;
        r1_valid = 1; r1_we = 0; r1_addr = 32'h20; r1_size = 2'b10;
        b_valid = 1;
        na = 0; nb = 0;
        for (int k = 0; k < 40 && (na < 4 || nb < 4); k++) begin
            #1;
            if ((r0_ready || r1_ready) && na < 4) begin
                grant_a[na] = {r1_ready, r0_ready}; na++;
            end
            if ((b_r0 || b_r1) && nb < 4) begin
                grant_b[nb] = {b_r1, b_r0}; nb++;
            end
            @(negedge clk);
        end
        r0_valid = 0; r1_valid = 0; b_valid = 0;
        chk("rr_count", na, 4);
        chk("fp_count", nb, 4);
        chk("rr_grants", {24'h0, grant_a[0], grant_a[1], grant_a[2], grant_a[3]}, 32'h66);
        chk("fp_grants", {24'h0, grant_b[0], grant_b[1], grant_b[2], grant_b[3]}, 32'h55);
        $display("arb rr=%b %b %b %b fp=%b %b %b %b", grant_a[0], grant_a[1], grant_a[2],
                 grant_a[3], grant_b[0], grant_b[1], grant_b[2], grant_b[3]);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer for the 32-word data memory; sits between the core load/store unit (port 0) and the debug/test loader (port 1) on one side and the data memory on the other.
- Arbitrates between the ports and aligns byte/half data to memory lanes.
- Implements sub-word stores as read-modify-write, so the memory only ever sees full-word writes.
- Rejects misaligned, invalid-size and out-of-range accesses with an error response.

Parameters:
- MEM_WORDS, 32, number of 32-bit words in the data memory; word index >= MEM_WORDS is out of range.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, port 0 always wins.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset; synchronous, active-high.
- reqN_valid_i  in  1  request valid, port N (N = 0, 1).
- reqN_ready_o  out  1  request accepted this cycle, port N.
- reqN_we_i  in  1  1 = store, 0 = load.
- reqN_addr_i  in  32  byte address.
- reqN_wdata_i  in  32  store data, right-justified.
- reqN_size_i  in  2  `SIZE_BYTE (00), `SIZE_HALF (01), word (10); 11 is invalid.
- respN_valid_o  out  1  one-cycle response pulse, port N.
- respN_rdata_o  out  32  load data, right-justified, zero-extended.
- respN_err_o  out  1  access rejected; qualified by respN_valid_o.
- daddr_o  out  32  memory word index, {2'b00, addr[31:2]}.
- dwdata_o  out  32  memory write data.
- drdata_i  in  32  memory read data; combinational, valid the same cycle drd_o is high.
- dsize_o  out  2  memory access size; always word (10) when a strobe is active.
- drd_o  out  1  memory read strobe.
- dwr_o  out  1  memory write strobe.
- dbe_o  out  4  memory byte enables; 4'b1111 when a strobe is active.

Behaviour:
- Reset: state IDLE, RR pointer favours port 0, latched request cleared.
- Every output is 0 during reset and whenever not explicitly driven below.
- States: IDLE, READ, MERGE, WRITE, RESP.

IDLE:
- Grant: if one port is valid, it wins. If both are valid, RR_EN=1 grants the port not granted last; RR_EN=0 grants port 0.
- reqN_ready_o = 1 combinationally for the granted port only; accept = valid & ready.
- On accept: latch we/addr/wdata/size and the owner ID; flip the RR pointer to the owner.
- Error check, in order: size=11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= MEM_WORDS. Any hit: latch err=1, go to RESP, no memory strobe.
- Otherwise the next state is: load -> READ; word store -> WRITE; byte/half store -> MERGE.

READ:
- drd_o=1, daddr_o driven.
- Capture rdata = drdata_i >> (8*addr[1:0]), masked to 8/16/32 bits by size.
- Go to RESP.

MERGE:
- drd_o=1.
- Lane mask: byte = 4'b0001 << addr[1:0]; half = 4'b0011 << addr[1:0].
- Shifted data = wdata << (8*addr[1:0]).
- Merged word = per byte, the shifted data where the mask bit is set, else drdata_i. Register it.
- Go to WRITE.

WRITE:
- dwr_o=1, dsize_o=word, dbe_o=4'b1111.
- dwdata_o = merged word for sub-word stores, latched wdata for word stores.
- Go to RESP.

RESP:
- respN_valid_o=1 for exactly one cycle, owner port only.
- rdata is the captured value for loads and 0 for stores and errors; err as latched.
- Go to IDLE; next accept is possible the following cycle.

Latency (accept at cycle T):
- error: resp at T+1.
- load or word store: resp at T+2.
- byte/half store: resp at T+3.

Other rules:
- Only one request is outstanding at a time; ready is 0 outside IDLE.
- A requester holds valid and its fields stable until ready. Changing them before accept is allowed; the values present at accept are used.
- A requester may not drop a response; there is no response backpressure.
- reset_i in any state returns to IDLE next cycle. An in-flight store not yet in WRITE never reaches memory; a pending response is discarded.
- Simultaneous new valid during RESP is not granted until IDLE.

Test Plan:
- Reset, then port0 word store addr 0x10 data 0xDEADBEEF: WRITE at T+1 with daddr_o=4, dbe_o=F. Then a word load of 0x10 gives resp0 rdata=0xDEADBEEF, err=0 at T+2.
- Byte store port0 addr 0x11 data 0xAB over word 0xDEADBEEF: MERGE then WRITE dwdata_o=0xDEADABEF. Byte load 0x13 returns 0x000000DE; half load 0x12 returns 0x0000DEAD.
- Both ports valid every cycle with RR_EN=1: grants alternate 0,1,0,1 starting with port 0 after reset. With RR_EN=0, port 0 is granted every time.
- Half load addr 0x05, word load addr 0x06, size 11, word load addr 0x80 (index 32): each gives resp at T+1 with err=1, rdata=0, drd_o/dwr_o never asserted.
- Port1 half store addr 0x22 issued, reset_i asserted in the MERGE cycle: dwr_o never asserts, resp1_valid_o stays 0, word 8 unchanged, next request accepted normally.
